// File: rtl/aes_iter_core.sv
// Iterative AES-128 encrypt/decrypt core. One shared 128-bit state register, SubBytes+ShiftRows
// in a single cycle, and (Inv)MixColumns spread over 4/COLS_PER_CYCLE cycles.

module aes_mix_col (
  input  logic        inv,
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [3:0][7:0] a, x2, x4, x8;

  // Inverse coefficients 0e/0b/0d/09 are built from the x2/x4/x8 doubling chain.
  always_comb begin
    a = '0; x2 = '0; x4 = '0; x8 = '0; col_o = '0;
    for (int i = 0; i < 4; i++) begin
      a[i]  = col_i[31-8*i -: 8];
      x2[i] = xt(a[i]);
      x4[i] = xt(x2[i]);
      x8[i] = xt(x4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      if (inv)
        col_o[31-8*i -: 8] = (x8[i] ^ x4[i] ^ x2[i])
                           ^ (x8[(i+1)%4] ^ x2[(i+1)%4] ^ a[(i+1)%4])
                           ^ (x8[(i+2)%4] ^ x4[(i+2)%4] ^ a[(i+2)%4])
                           ^ (x8[(i+3)%4] ^ a[(i+3)%4]);
      else
        col_o[31-8*i -: 8] = x2[i] ^ x2[(i+1)%4] ^ a[(i+1)%4] ^ a[(i+2)%4] ^ a[(i+3)%4];
    end
  end
endmodule

module aes_iter_core #(
  parameter int COLS_PER_CYCLE = 1,
  parameter int KEY_WAIT       = 12
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          AES_START,
  input  logic          AES_MODE,
  input  logic [127:0]  AES_MSG_IN,
  input  logic [1407:0] AES_KEY_SCHEDULE,
  output logic [127:0]  AES_MSG_OUT,
  output logic          AES_DONE,
  output logic          AES_BUSY
);
  localparam int M  = 4 / ((COLS_PER_CYCLE > 0) ? COLS_PER_CYCLE : 1);
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam logic [4:0] KW_LAST = 5'((KEY_WAIT > 0) ? KEY_WAIT - 1 : 0);

  if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
    $error("aes_iter_core: COLS_PER_CYCLE must be 1, 2 or 4");
  end
  if (KEY_WAIT < 0 || KEY_WAIT > 31) begin : g_bad_kw
    $error("aes_iter_core: KEY_WAIT must be in 0..31");
  end

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse table is derived from the forward one at elaboration so the two cannot disagree.
  function automatic logic [2047:0] build_inv_sbox();
    logic [2047:0] r;
    r = '0;
    for (int i = 0; i < 256; i++)
      r[2047-8*int'(SBOX[2047-8*i -: 8]) -: 8] = 8'(i);
    return r;
  endfunction
  localparam logic [2047:0] INV_SBOX = build_inv_sbox();

  function automatic logic [7:0] sb(input logic [7:0] x);
    return SBOX[2047-8*int'(x) -: 8];
  endfunction
  function automatic logic [7:0] isb(input logic [7:0] x);
    return INV_SBOX[2047-8*int'(x) -: 8];
  endfunction

  typedef enum logic [2:0] {
    S_IDLE, S_KEY_WAIT, S_INIT_ARK, S_SUB_SHIFT, S_MIX, S_ARK, S_DONE
  } fsm_e;

  fsm_e            fsm_q, fsm_d;
  logic [3:0]      rnd_q;
  logic [4:0]      kw_cnt;
  logic [MW-1:0]   mix_cnt;
  logic            mix_last;
  logic            mode_q;
  logic [127:0]    state_q, ss_out, rk_sel;
  logic [3:0]      rk_idx;
  logic [1:0]      col_base;
  logic [3:0][31:0] st_cols, mix_cols;
  logic [COLS_PER_CYCLE-1:0][31:0] mix_out;

  assign mix_last = (mix_cnt == MW'(M - 1));
  assign st_cols  = state_q;
  assign col_base = 2'(int'(mix_cnt) * COLS_PER_CYCLE);

  // Column j lives at st_cols[3-j], i.e. st_cols[~j] for a 2-bit j.
  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    logic [1:0] ci;
    assign ci = col_base + 2'(i);
    aes_mix_col u_mix (.inv(!mode_q), .col_i(st_cols[~ci]), .col_o(mix_out[i]));
  end

  always_comb begin
    logic [1:0] ci;
    ci       = '0;
    mix_cols = st_cols;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      ci = col_base + 2'(i);
      mix_cols[~ci] = mix_out[i];
    end
  end

  always_comb begin
    ss_out = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        ss_out[127-8*(r+4*c) -: 8] = mode_q ? sb(state_q[127-8*(r+4*((c+r)%4)) -: 8])
                                             : isb(state_q[127-8*(r+4*((c-r+4)%4)) -: 8]);
  end

  always_comb begin
    rk_idx = 4'd0;
    if (fsm_q == S_INIT_ARK) rk_idx = mode_q ? 4'd0 : 4'd10;
    else if (fsm_q == S_ARK) rk_idx = mode_q ? rnd_q : 4'd10 - rnd_q;
  end
  assign rk_sel = AES_KEY_SCHEDULE[1407-128*int'(rk_idx) -: 128];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      fsm_q   <= S_IDLE;
      rnd_q   <= '0;
      kw_cnt  <= '0;
      mix_cnt <= '0;
    end else begin
      fsm_q   <= fsm_d;
      kw_cnt  <= (fsm_q == S_KEY_WAIT) ? kw_cnt + 5'd1 : 5'd0;
      mix_cnt <= (fsm_q == S_MIX && !mix_last) ? mix_cnt + MW'(1) : '0;
      if (fsm_q == S_IDLE && AES_START)                           rnd_q <= 4'd1;
      else if (fsm_q == S_MIX && mix_last && !mode_q)             rnd_q <= rnd_q + 4'd1;
      else if (fsm_q == S_ARK && (mode_q || rnd_q == 4'd10))      rnd_q <= rnd_q + 4'd1;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      S_IDLE:      if (AES_START) fsm_d = (KEY_WAIT == 0) ? S_INIT_ARK : S_KEY_WAIT;
      S_KEY_WAIT:  if (kw_cnt == KW_LAST) fsm_d = S_INIT_ARK;
      S_INIT_ARK:  fsm_d = S_SUB_SHIFT;
      S_SUB_SHIFT: fsm_d = (rnd_q == 4'd10 || !mode_q) ? S_ARK : S_MIX;
      S_MIX:       if (mix_last) fsm_d = mode_q ? S_ARK : S_SUB_SHIFT;
      S_ARK:       fsm_d = (rnd_q == 4'd10) ? S_DONE : (mode_q ? S_SUB_SHIFT : S_MIX);
      S_DONE:      if (!AES_START) fsm_d = S_IDLE;
      default:     fsm_d = S_IDLE;
    endcase
  end

  always_comb begin
    AES_BUSY = !(fsm_q == S_IDLE || fsm_q == S_DONE);
    AES_DONE = (fsm_q == S_DONE);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= '0;
      mode_q      <= 1'b0;
      AES_MSG_OUT <= '0;
    end else begin
      case (fsm_q)
        S_IDLE:      if (AES_START) begin
                       state_q <= AES_MSG_IN;
                       mode_q  <= AES_MODE;
                     end
        S_INIT_ARK:  state_q <= state_q ^ rk_sel;
        S_SUB_SHIFT: state_q <= ss_out;
        S_MIX:       state_q <= mix_cols;
        S_ARK: begin
          state_q <= state_q ^ rk_sel;
          if (rnd_q == 4'd10) AES_MSG_OUT <= state_q ^ rk_sel;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/aes_iter_core.md
AES_ITER_CORE -- requirements
Module: aes_iter_core

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1, meaning (Inv)MixColumns columns processed per cycle; legal values 1, 2, 4; other values SHALL fail elaboration.
REQ-002 Parameter KEY_WAIT, default 12, meaning cycles waited after start for AES_KEY_SCHEDULE to settle; legal 0-31.
REQ-003 CLK  input  1  single clock; all state on rising edge.
REQ-004 RESET_N  input  1  asynchronous, active-low reset.
REQ-005 AES_START  input  1  request; level-sensitive handshake with AES_DONE.
REQ-006 AES_MODE  input  1  0 = decrypt, 1 = encrypt; sampled with AES_START.
REQ-007 AES_MSG_IN  input  128  input block; sampled with AES_START.
REQ-008 AES_KEY_SCHEDULE  input  1408  round keys rk0..rk10; rk r at bits [1407-128r : 1280-128r] (rk0 in MSBs); held stable from start until AES_DONE.
REQ-009 AES_MSG_OUT  output  128  registered result.
REQ-010 AES_DONE  output  1  result valid.
REQ-011 AES_BUSY  output  1  high in every state except IDLE and DONE.

Function
REQ-012 FSM states SHALL be IDLE, KEY_WAIT, INIT_ARK, SUB_SHIFT, MIX, ARK, DONE; 4-bit round counter RND; mix column counter of width log2(4/COLS_PER_CYCLE) (zero width when COLS_PER_CYCLE = 4).
REQ-013 IDLE: on AES_START = 1, capture AES_MSG_IN into state register and AES_MODE into mode register, set RND = 1, go to KEY_WAIT (INIT_ARK if KEY_WAIT = 0).
REQ-014 KEY_WAIT: hold exactly KEY_WAIT cycles, then INIT_ARK.
REQ-015 INIT_ARK (1 cycle): state ^= rk0 when encrypting, rk10 when decrypting; next SUB_SHIFT.
REQ-016 SUB_SHIFT (1 cycle): encrypt applies SubBytes then ShiftRows; decrypt applies InvShiftRows then InvSubBytes.
REQ-017 Encrypt order per round: SUB_SHIFT, MIX, ARK(rk RND); decrypt order: SUB_SHIFT, ARK(rk 10-RND), MIX (InvMixColumns).
REQ-018 MIX lasts M = 4/COLS_PER_CYCLE cycles; each cycle transforms COLS_PER_CYCLE columns in place, column 0 = bits [127:96] first.
REQ-019 Round 10 SHALL skip MIX: encrypt SUB_SHIFT then ARK(rk10); decrypt SUB_SHIFT then ARK(rk0).
REQ-020 RND increments when a round completes; after round 10, load state into AES_MSG_OUT and enter DONE.
REQ-021 Latency: DONE entered exactly KEY_WAIT + 1 + 9*(2+M) + 2 edges after the edge sampling AES_START (69 for defaults, 42 for COLS_PER_CYCLE = 4).
REQ-022 DONE: AES_DONE = 1 while AES_START = 1; on AES_START = 0 return to IDLE (AES_DONE low next cycle).
REQ-023 AES_MSG_OUT SHALL hold its value until the next completion; it SHALL NOT change during a later operation.
REQ-024 AES_START, AES_MODE, AES_MSG_IN changes while AES_BUSY = 1 SHALL be ignored.
REQ-025 Encrypt and decrypt SHALL share a single state register; S-box and inverse S-box are combinational lookup.

Reset
REQ-026 RESET_N = 0 SHALL immediately force IDLE, RND = 0, state register = 0, AES_MSG_OUT = 0, AES_DONE = 0, AES_BUSY = 0, independent of CLK.
REQ-027 Reset asserted mid-operation SHALL abort without updating AES_MSG_OUT beyond its reset value; the first operation after release SHALL behave as from power-up.

Verification
REQ-028 FIPS-197 C.1 encrypt: key 000102030405060708090a0b0c0d0e0f schedule, MODE=1, MSG 00112233445566778899aabbccddeeff -> AES_MSG_OUT 69c4e0d86a7b0430d8cdb78070b4c55a, AES_DONE at edge 69.
REQ-029 Same key, MODE=0, MSG 69c4e0d86a7b0430d8cdb78070b4c55a -> 00112233445566778899aabbccddeeff; repeat with COLS_PER_CYCLE = 2 (DONE at edge 51) and 4 (edge 42).
REQ-030 KEY_WAIT = 0, defaults otherwise -> DONE at edge 57, result unchanged.
REQ-031 Toggle AES_MSG_IN and AES_MODE every cycle while busy -> result equals the block captured at start; AES_START held high in DONE keeps AES_DONE = 1, AES_MSG_OUT stable; drop START -> IDLE next cycle.
REQ-032 Assert RESET_N = 0 at cycle 30 of an operation -> all outputs 0 same cycle; after release, restart C.1 encrypt -> correct result at edge 69.
REQ-033 Random key/message pairs checked against a reference model in both modes and all COLS_PER_CYCLE values, back-to-back with one IDLE cycle between operations.
